sa_wrr_arbiter: RTL and testbench

SA_WRR_ARBITER -- requirements
Module: sa_wrr_arbiter

---
 rtl/sa_wrr_arbiter.sv | 103 ++++++++++
 tb/tb_sa_wrr_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_wrr_arbiter.sv
// Weighted round-robin / fixed-priority request arbiter with a single registered
// output slot; the winner's payload and index are held until downstream accepts.
module sa_wrr_arbiter #(
  parameter int                        REQ_AMT    = 4,
  parameter int                        REQ_ID_W   = $clog2(REQ_AMT),
  parameter int                        PAYLOAD_W  = 45,
  parameter logic [0:(REQ_AMT*32)-1]   REQ_WEIGHT = {32'd5, 32'd3, 32'd2, 32'd1},
  parameter int                        CREDIT_W   = 8,
  parameter int                        ARB_MODE   = 0
) (
  input  logic                           ACLK_i,
  input  logic                           ARESETn_i,
  input  logic [REQ_AMT-1:0]             req_valid_i,
  input  logic [PAYLOAD_W*REQ_AMT-1:0]   req_payload_i,
  input  logic [REQ_AMT-1:0]             req_block_i,
  input  logic                           stall_i,
  input  logic                           out_ready_i,
  output logic [REQ_AMT-1:0]             req_ready_o,
  output logic                           out_valid_o,
  output logic [PAYLOAD_W-1:0]           out_payload_o,
  output logic [REQ_ID_W-1:0]            out_id_o,
  output logic                           ord_wr_en_o
);

  localparam int IDX_W = (REQ_ID_W > 0) ? REQ_ID_W : 1;

  function automatic logic [CREDIT_W-1:0] eff_weight(input int idx);
    logic [31:0]         w;
    logic [CREDIT_W-1:0] t;
    w = REQ_WEIGHT[idx*32 +: 32];
    t = CREDIT_W'(w);
    return (t == '0) ? CREDIT_W'(1) : t;
  endfunction

  logic [REQ_AMT-1:0]  eligible;
  logic                load;
  logic                arb_p0;
  logic [IDX_W-1:0]    win_id_p0;
  logic                keep_p0;
  logic                found;
  logic [IDX_W-1:0]    ptr;
  logic [CREDIT_W-1:0] credit;

  // Stage p0: combinational arbitration
  assign eligible = req_valid_i & ~req_block_i & {REQ_AMT{~stall_i}};
  assign load     = ~out_valid_o | out_ready_i;
  assign arb_p0   = load & (|eligible);

  always_comb begin
    win_id_p0 = '0;
    keep_p0   = 1'b0;
    found     = 1'b0;
    if (ARB_MODE == 1) begin
      for (int i = REQ_AMT - 1; i >= 0; i--) begin
        if (eligible[i]) win_id_p0 = IDX_W'(i);
      end
    end else if (eligible[ptr] && (credit != '0)) begin
      win_id_p0 = ptr;
      keep_p0   = 1'b1;
    end else begin
      // Search starts just after the last winner and ends on it.
      for (int k = 1; k <= REQ_AMT; k++) begin
        if (!found && eligible[(int'(ptr) + k) % REQ_AMT]) begin
          win_id_p0 = IDX_W'((int'(ptr) + k) % REQ_AMT);
          found     = 1'b1;
        end
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (arb_p0 && ARESETn_i) req_ready_o[win_id_p0] = 1'b1;
  end

  // Stage p1: registered winner and quota state
  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) begin
      ptr           <= IDX_W'(REQ_AMT - 1);
      credit        <= '0;
      out_valid_o   <= 1'b0;
      out_payload_o <= '0;
      out_id_o      <= '0;
    end else if (load) begin
      out_valid_o <= |eligible;
      if (arb_p0) begin
        out_payload_o <= req_payload_i[int'(win_id_p0)*PAYLOAD_W +: PAYLOAD_W];
        out_id_o      <= REQ_ID_W'(win_id_p0);
        if (ARB_MODE == 0) begin
          if (keep_p0) begin
            credit <= credit - CREDIT_W'(1);
          end else begin
            ptr    <= win_id_p0;
            credit <= eff_weight(int'(win_id_p0)) - CREDIT_W'(1);
          end
        end
      end
    end
  end

  assign ord_wr_en_o = out_valid_o & out_ready_i & ARESETn_i;

endmodule

// File: tb/tb_sa_wrr_arbiter.sv
// Self-checking bench for sa_wrr_arbiter: scripted quota scenarios plus a
// randomized run against a behavioural WRR model.
module tb_sa_wrr_arbiter;
  localparam int N  = 4;
  localparam int PW = 45;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [PW*N-1:0]   req_payload = '0;
  logic [N-1:0]      req_block = '0;
  logic              stall = 1'b0;
  logic              out_ready = 1'b1;

  logic [N-1:0]      req_ready, fp_req_ready;
  logic              out_valid, fp_out_valid;
  logic [PW-1:0]     out_payload, fp_out_payload;
  logic [1:0]        out_id, fp_out_id;
  logic              ord_wr_en, fp_ord_wr_en;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sa_wrr_arbiter dut (
    .ACLK_i(clk), .ARESETn_i(rst_n), .req_valid_i(req_valid), .req_payload_i(req_payload),
    .req_block_i(req_block), .stall_i(stall), .out_ready_i(out_ready),
    .req_ready_o(req_ready), .out_valid_o(out_valid), .out_payload_o(out_payload),
    .out_id_o(out_id), .ord_wr_en_o(ord_wr_en)
  );

  sa_wrr_arbiter #(.ARB_MODE(1)) dut_fp (
    .ACLK_i(clk), .ARESETn_i(rst_n), .req_valid_i(req_valid), .req_payload_i(req_payload),
    .req_block_i(req_block), .stall_i(stall), .out_ready_i(out_ready),
    .req_ready_o(fp_req_ready), .out_valid_o(fp_out_valid), .out_payload_o(fp_out_payload),
    .out_id_o(fp_out_id), .ord_wr_en_o(fp_ord_wr_en)
  );

  // Behavioural WRR model: current owner, grants left for it, and the output slot.
  int           weight [N] = '{5, 3, 2, 1};
  int           m_ptr, m_credit, m_id, exp_win;
  bit           m_cont, m_load;
  logic         m_ov;
  logic [PW-1:0] m_pay;
  logic [PW-1:0] pay_arr [N];

  task automatic model_reset();
    m_ptr = N - 1; m_credit = 0; m_ov = 1'b0; m_pay = '0; m_id = 0;
  endtask

  task automatic model_eval();
    logic [N-1:0] elig;
    int order[$];
    elig    = req_valid & ~req_block & {N{~stall}};
    m_load  = !m_ov || out_ready;
    exp_win = -1;
    m_cont  = 1'b0;
    if (m_load && elig != 0) begin
      if (elig[m_ptr] && m_credit > 0) begin
        exp_win = m_ptr;
        m_cont  = 1'b1;
      end else begin
        for (int k = 1; k <= N; k++) order.push_back((m_ptr + k) % N);
        foreach (order[j]) if (exp_win < 0 && elig[order[j]]) exp_win = order[j];
      end
    end
  endtask

  task automatic model_commit();
    logic [N-1:0] elig;
    elig = req_valid & ~req_block & {N{~stall}};
    if (m_load) begin
      m_ov = (elig != 0);
      if (exp_win >= 0) begin
        m_pay = req_payload[exp_win*PW +: PW];
        m_id  = exp_win;
        if (m_cont) m_credit = m_credit - 1;
        else begin m_ptr = exp_win; m_credit = weight[exp_win] - 1; end
      end
    end
  endtask

  task automatic set_payloads();
    for (int i = 0; i < N; i++) begin
      pay_arr[i] = PW'({$urandom, $urandom});
      req_payload[i*PW +: PW] = pay_arr[i];
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    set_payloads();
    req_valid = 4'b1111; out_ready = 1'b1; stall = 1'b0; req_block = '0;
    rst_n = 1'b0;
    @(negedge clk); #1;
    checks++; if (req_ready !== 4'b0000 || fp_req_ready !== 4'b0000) begin errors++;
      $display("FAIL reset_ready: got %b/%b expected 0000", req_ready, fp_req_ready); end
    checks++; if (out_valid !== 1'b0 || ord_wr_en !== 1'b0) begin errors++;
      $display("FAIL reset_valid: got valid=%b ord=%b expected 0/0", out_valid, ord_wr_en); end
    checks++; if (out_id !== 2'd0 || out_payload !== '0) begin errors++;
      $display("FAIL reset_data: got id=%0d payload=%0h expected 0/0", out_id, out_payload); end
    rst_n = 1'b1; #1;
    checks++; if (req_ready !== 4'b0001) begin errors++;
      $display("FAIL reset_first_grant: got %b expected 0001", req_ready); end
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_id !== 2'd0 || out_payload !== pay_arr[0]) begin errors++;
      $display("FAIL reset_first_out: got v=%b id=%0d expected v=1 id=0", out_valid, out_id); end
  endtask

  task automatic test_wrr_sequence();
    int seq [11] = '{0, 0, 0, 0, 0, 1, 1, 1, 2, 2, 3};
    int prev;
    req_valid = 4'b1111; out_ready = 1'b1;
    do_reset();
    for (int c = 0; c < 22; c++) begin
      #1;
      checks++; if (req_ready !== 4'(1 << seq[c % 11])) begin errors++;
        $display("FAIL wrr_seq_ready[%0d]: got %b expected %b", c, req_ready, 4'(1 << seq[c % 11])); end
      if (c > 0) begin
        prev = seq[(c - 1) % 11];
        checks++; if (out_id !== 2'(prev) || out_payload !== pay_arr[prev] || ord_wr_en !== 1'b1) begin errors++;
          $display("FAIL wrr_seq_out[%0d]: got id=%0d ord=%b expected id=%0d ord=1", c, out_id, ord_wr_en, prev); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_drop_return();
    int seq [14] = '{0, 0, 1, 1, 1, 2, 2, 3, 0, 0, 0, 0, 0, 1};
    req_valid = 4'b1111; out_ready = 1'b1;
    do_reset();
    for (int c = 0; c < 14; c++) begin
      req_valid = (c >= 2 && c < 8) ? 4'b1110 : 4'b1111;
      #1;
      checks++; if (req_ready !== 4'(1 << seq[c])) begin errors++;
        $display("FAIL drop_return[%0d]: got %b expected %b", c, req_ready, 4'(1 << seq[c])); end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    int seq [9] = '{0, 0, 0, 1, 1, 1, 2, 2, 3};
    logic [PW-1:0] held;
    req_valid = 4'b1111; out_ready = 1'b1;
    do_reset();
    repeat (2) @(negedge clk);
    held = pay_arr[0];
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      req_payload = ~req_payload;
      #1;
      checks++; if (req_ready !== 4'b0000 || ord_wr_en !== 1'b0) begin errors++;
        $display("FAIL bp_ready[%0d]: got %b ord=%b expected 0000 ord=0", c, req_ready, ord_wr_en); end
      checks++; if (out_valid !== 1'b1 || out_id !== 2'd0 || out_payload !== held) begin errors++;
        $display("FAIL bp_hold[%0d]: got v=%b id=%0d pay=%0h expected v=1 id=0 pay=%0h", c, out_valid, out_id, out_payload, held); end
      @(negedge clk);
    end
    for (int i = 0; i < N; i++) req_payload[i*PW +: PW] = pay_arr[i];
    out_ready = 1'b1;
    for (int c = 0; c < 9; c++) begin
      #1;
      checks++; if (req_ready !== 4'(1 << seq[c])) begin errors++;
        $display("FAIL bp_resume[%0d]: got %b expected %b", c, req_ready, 4'(1 << seq[c])); end
      @(negedge clk);
    end
  endtask

  task automatic test_stall_block();
    req_valid = 4'b1111; out_ready = 1'b1; req_block = '0;
    do_reset();
    @(negedge clk);
    stall = 1'b1; #1;
    checks++; if (req_ready !== 4'b0000 || ord_wr_en !== 1'b1) begin errors++;
      $display("FAIL stall_same_cycle: got %b ord=%b expected 0000 ord=1", req_ready, ord_wr_en); end
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b0 || ord_wr_en !== 1'b0) begin errors++;
      $display("FAIL stall_drain: got v=%b ord=%b expected 0/0", out_valid, ord_wr_en); end
    stall = 1'b0; req_block = 4'b0010;
    for (int c = 0; c < 24; c++) begin
      #1;
      checks++; if (req_ready[1] !== 1'b0 || $countones(req_ready) != 1) begin errors++;
        $display("FAIL block_req1[%0d]: got %b expected one-hot without bit 1", c, req_ready); end
      @(negedge clk);
    end
    req_block = '0;
  endtask

  task automatic test_random();
    req_valid = 4'b0000; out_ready = 1'b1; stall = 1'b0; req_block = '0;
    do_reset();
    model_reset();
    for (int c = 0; c < 400; c++) begin
      req_valid = 4'($urandom);
      req_block = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      stall     = ($urandom_range(0, 9) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      set_payloads();
      #1;
      model_eval();
      checks++; if (req_ready !== ((exp_win >= 0) ? 4'(1 << exp_win) : 4'b0000)) begin errors++;
        $display("FAIL rand_ready[%0d]: got %b expected winner %0d", c, req_ready, exp_win); end
      checks++; if (out_valid !== m_ov || ord_wr_en !== (m_ov & out_ready)) begin errors++;
        $display("FAIL rand_valid[%0d]: got v=%b ord=%b expected v=%b", c, out_valid, ord_wr_en, m_ov); end
      if (m_ov) begin
        checks++; if (out_id !== 2'(m_id) || out_payload !== m_pay) begin errors++;
          $display("FAIL rand_out[%0d]: got id=%0d pay=%0h expected id=%0d pay=%0h", c, out_id, out_payload, m_id, m_pay); end
      end
      @(posedge clk);
      model_commit();
      @(negedge clk);
    end
    stall = 1'b0; req_block = '0; out_ready = 1'b1;
  endtask

  task automatic test_fixed_priority();
    req_valid = 4'b1110; out_ready = 1'b1;
    do_reset();
    for (int c = 0; c < 20; c++) begin
      if (c == 10) req_valid = 4'b1111;
      #1;
      checks++; if (fp_req_ready !== ((c < 10) ? 4'b0010 : 4'b0001)) begin errors++;
        $display("FAIL fp_ready[%0d]: got %b", c, fp_req_ready); end
      if (c > 0 && c != 10) begin
        checks++; if (fp_out_id !== ((c < 10) ? 2'd1 : 2'd0) || fp_out_valid !== 1'b1) begin errors++;
          $display("FAIL fp_out_id[%0d]: got %0d v=%b", c, fp_out_id, fp_out_valid); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_midtransfer();
    req_valid = 4'b1111; out_ready = 1'b1;
    do_reset();
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0; #1;
    checks++; if (out_valid !== 1'b0 || req_ready !== 4'b0000 || ord_wr_en !== 1'b0) begin errors++;
      $display("FAIL midreset_clear: got v=%b rdy=%b ord=%b expected 0/0000/0", out_valid, req_ready, ord_wr_en); end
    @(negedge clk);
    rst_n = 1'b1; #1;
    checks++; if (req_ready !== 4'b0001) begin errors++;
      $display("FAIL midreset_first: got %b expected 0001", req_ready); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_wrr_sequence();
    test_drop_return();
    test_backpressure();
    test_stall_block();
    test_random();
    test_fixed_priority();
    test_reset_midtransfer();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1);
  end
endmodule
